// File: rtl/muldiv_seq_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   MD_WIDTH   : default operand width (HI/LO are each this wide)
//   md_op_e    : MdOp encodings (bit 1 selects divide, bit 0 selects unsigned)
//   md_state_e : control FSM states
package muldiv_seq_pkg;

  localparam int MD_WIDTH = 32;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_FIX  = 2'b10,
    S_ZERO = 2'b11
  } md_state_e;

endpackage

// File: rtl/muldiv_step.sv
// Combinational (WIDTH+1)-bit adder/subtractor shared by the multiply and
// divide iterations.
//   a_i    : left operand (partial product high half or shifted remainder)
//   b_i    : right operand (multiplicand or divisor, zero-extended)
//   sub_i  : 1 = a_i - b_i, 0 = a_i + b_i
//   res_o  : (WIDTH+1)-bit result
//   cout_o : carry out; in subtract mode 1 means "no borrow" (a_i >= b_i)
module muldiv_step
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH
) (
  input  logic [WIDTH:0] a_i,
  input  logic [WIDTH:0] b_i,
  input  logic           sub_i,
  output logic [WIDTH:0] res_o,
  output logic           cout_o
);

  logic [WIDTH:0]   b_eff;
  logic [WIDTH+1:0] sum;

  assign b_eff  = sub_i ? ~b_i : b_i;
  assign sum    = {1'b0, a_i} + {1'b0, b_eff} + {{(WIDTH+1){1'b0}}, sub_i};
  assign res_o  = sum[WIDTH:0];
  assign cout_o = sum[WIDTH+1];

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle integer multiply/divide unit producing the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide on magnitudes, with sign
// correction in a final FIX cycle; fixed 33-cycle latency from the Start edge.
//   clk, reset : clock, synchronous active-high reset
//   Start      : launch an operation (only honoured in IDLE)
//   MdOp       : 00 mult, 01 multu, 10 div, 11 divu
//   A, B       : multiplicand/dividend, multiplier/divisor
//   MtHi, MtLo : direct writes of WData into Hi/Lo (IDLE without Start only)
//   WData      : mthi/mtlo data
//   Busy       : operation in flight
//   Done       : one-cycle pulse after Hi/Lo are written by an operation
//   DivZero    : sticky divide-by-zero flag, cleared by the next accepted Start
//   Hi, Lo     : result registers
module muldiv_seq
  import muldiv_seq_pkg::*;
#(
  parameter int WIDTH = MD_WIDTH,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Start,
  input  logic [1:0]       MdOp,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             MtHi,
  input  logic             MtLo,
  input  logic [WIDTH-1:0] WData,
  output logic             Busy,
  output logic             Done,
  output logic             DivZero,
  output logic [WIDTH-1:0] Hi,
  output logic [WIDTH-1:0] Lo
);

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
    return -x;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] x);
    return -x;
  endfunction

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Operation context and accumulators: {acc_hi, acc_lo} is the product
  // accumulator for multiply and {rem, quo} for divide; opd holds the
  // multiplicand or divisor magnitude.
  logic             is_div_q, is_div_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] opd_q, opd_d;

  logic             op_signed;
  logic [WIDTH-1:0] abs_a, abs_b;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   step_a;
  logic [WIDTH:0]   step_res;
  logic             step_cout;
  logic [WIDTH:0]   add_sum;
  logic [2*WIDTH-1:0] prod_fix;

  assign op_signed = ~MdOp[0];
  assign abs_a = (op_signed && A[WIDTH-1]) ? neg_w(A) : A;
  assign abs_b = (op_signed && B[WIDTH-1]) ? neg_w(B) : B;

  // Divide: remainder shifted left with the next dividend bit from the quotient
  // register. Multiply: upper half zero-extended so the carry is kept.
  assign rem_sh = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign step_a = is_div_q ? rem_sh : {1'b0, acc_hi_q};

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .a_i    (step_a),
    .b_i    ({1'b0, opd_q}),
    .sub_i  (is_div_q),
    .res_o  (step_res),
    .cout_o (step_cout)
  );

  assign add_sum  = acc_lo_q[0] ? step_res : {1'b0, acc_hi_q};
  assign prod_fix = qneg_q ? neg_2w({acc_hi_q, acc_lo_q}) : {acc_hi_q, acc_lo_q};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    done_d   = 1'b0;
    dz_d     = dz_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    is_div_d = is_div_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opd_d    = opd_q;

    unique case (state_q)
      S_IDLE: begin
        if (Start) begin
          dz_d     = 1'b0;
          is_div_d = MdOp[1];
          qneg_d   = op_signed & (A[WIDTH-1] ^ B[WIDTH-1]);
          rneg_d   = op_signed & A[WIDTH-1];
          cnt_d    = CNT_W'(WIDTH - 1);
          if (MdOp[1] && (B == '0)) begin
            // Raw dividend is what ends up in Hi for a zero divisor.
            acc_hi_d = A;
            state_d  = S_ZERO;
          end else begin
            acc_hi_d = '0;
            opd_d    = MdOp[1] ? abs_b : abs_a;
            acc_lo_d = MdOp[1] ? abs_a : abs_b;
            state_d  = S_RUN;
          end
        end else begin
          if (MtHi) hi_d = WData;
          if (MtLo) lo_d = WData;
        end
      end

      S_RUN: begin
        if (is_div_q) begin
          // Carry out of the trial subtract is the new quotient bit.
          acc_hi_d = step_cout ? step_res[WIDTH-1:0] : rem_sh[WIDTH-1:0];
          acc_lo_d = {acc_lo_q[WIDTH-2:0], step_cout};
        end else begin
          acc_hi_d = add_sum[WIDTH:1];
          acc_lo_d = {add_sum[0], acc_lo_q[WIDTH-1:1]};
        end
        if (cnt_q == '0) begin
          state_d = S_FIX;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      S_FIX: begin
        if (is_div_q) begin
          hi_d = rneg_q ? neg_w(acc_hi_q) : acc_hi_q;
          lo_d = qneg_q ? neg_w(acc_lo_q) : acc_lo_q;
        end else begin
          hi_d = prod_fix[2*WIDTH-1:WIDTH];
          lo_d = prod_fix[WIDTH-1:0];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      S_ZERO: begin
        hi_d    = acc_hi_q;
        lo_d    = '1;
        dz_d    = 1'b1;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_ff @(posedge clk) begin
    is_div_q <= is_div_d;
    qneg_q   <= qneg_d;
    rneg_q   <= rneg_d;
    acc_hi_q <= acc_hi_d;
    acc_lo_q <= acc_lo_d;
    opd_q    <= opd_d;
  end

  assign Busy    = (state_q != S_IDLE);
  assign Done    = done_q;
  assign DivZero = dz_q;
  assign Hi      = hi_q;
  assign Lo      = lo_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;
  import muldiv_seq_pkg::*;

  logic        clk;
  logic        reset;
  logic        Start;
  logic [1:0]  MdOp;
  logic [31:0] A, B;
  logic        MtHi, MtLo;
  logic [31:0] WData;
  logic        Busy, Done, DivZero;
  logic [31:0] Hi, Lo;

  int errors = 0;
  int checks = 0;

  muldiv_seq dut (
    .clk     (clk),
    .reset   (reset),
    .Start   (Start),
    .MdOp    (MdOp),
    .A       (A),
    .B       (B),
    .MtHi    (MtHi),
    .MtLo    (MtLo),
    .WData   (WData),
    .Busy    (Busy),
    .Done    (Done),
    .DivZero (DivZero),
    .Hi      (Hi),
    .Lo      (Lo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: plain 64-bit arithmetic on the operands.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, q, r;
    logic [63:0] p, qv, rv;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op[1] && b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      case (op)
        2'b00: begin p = 64'(sa * sb); hi = p[63:32]; lo = p[31:0]; end
        2'b01: begin p = {32'd0, a} * {32'd0, b}; hi = p[63:32]; lo = p[31:0]; end
        2'b10: begin
          q = sa / sb; r = sa % sb;
          qv = 64'(q); rv = 64'(r);
          hi = rv[31:0]; lo = qv[31:0];
        end
        default: begin hi = a % b; lo = a / b; end
      endcase
    end
  endfunction

  // Launches one operation and follows it; lat = edges from the Start edge
  // until Done is seen (-1 if never), dones = Done cycles seen, held = Hi/Lo
  // stayed unchanged while Busy.
  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input bit mtlo, input logic [31:0] wd,
                        output int lat, output int dones, output bit held);
    logic [31:0] h0, l0;
    h0 = Hi; l0 = Lo;
    MdOp = op; A = a; B = b; Start = 1'b1;
    MtLo = mtlo; WData = wd;
    @(negedge clk);
    Start = 1'b0; MtLo = 1'b0;
    lat = -1; dones = 0; held = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      if (Busy && (Hi !== h0 || Lo !== l0)) held = 1'b0;
      @(negedge clk);
      if (Done === 1'b1) begin
        dones++;
        if (lat < 0) lat = c;
      end
      if (lat >= 0 && c >= lat + 2) break;
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; Start = 1'b0; MtHi = 1'b0; MtLo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", Done); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL reset_dz: got %b want 0", DivZero); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL reset_hi: got %h want 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL reset_lo: got %h want 0", Lo); end
  endtask

  task automatic test_directed();
    logic [1:0]  ops [5] = '{MD_MULTU, MD_MULT, MD_MULTU, MD_DIV, MD_DIV};
    logic [31:0] as  [5] = '{32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFF9, 32'h8000_0000};
    logic [31:0] bs  [5] = '{32'd6, 32'd5, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFF};
    logic [31:0] eh  [5] = '{32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0};
    logic [31:0] el  [5] = '{32'h2A, 32'hFFFF_FFF1, 32'h1, 32'hFFFF_FFFD, 32'h8000_0000};
    int lat, dn;
    bit held;
    for (int i = 0; i < 5; i++) begin
      run_op(ops[i], as[i], bs[i], 1'b0, 32'd0, lat, dn, held);
      checks++; if (Hi !== eh[i]) begin errors++; $display("FAIL dir%0d_hi: got %h want %h", i, Hi, eh[i]); end
      checks++; if (Lo !== el[i]) begin errors++; $display("FAIL dir%0d_lo: got %h want %h", i, Lo, el[i]); end
      checks++; if (lat != 33) begin errors++; $display("FAIL dir%0d_latency: got %0d want 33", i, lat); end
      checks++; if (dn != 1) begin errors++; $display("FAIL dir%0d_done_count: got %0d want 1", i, dn); end
      checks++; if (!held) begin errors++; $display("FAIL dir%0d_hilo_held: got 0 want 1", i); end
    end
  endtask

  task automatic test_divzero();
    int lat, dn;
    bit held;
    run_op(MD_DIVU, 32'd100, 32'd0, 1'b0, 32'd0, lat, dn, held);
    checks++; if (lat != 1) begin errors++; $display("FAIL dz_latency: got %0d want 1", lat); end
    checks++; if (Lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dz_lo: got %h want ffffffff", Lo); end
    checks++; if (Hi !== 32'd100) begin errors++; $display("FAIL dz_hi: got %h want 00000064", Hi); end
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_flag: got %b want 1", DivZero); end
    repeat (3) @(negedge clk);
    checks++; if (DivZero !== 1'b1) begin errors++; $display("FAIL dz_sticky: got %b want 1", DivZero); end
    run_op(MD_MULTU, 32'd1, 32'd1, 1'b0, 32'd0, lat, dn, held);
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL dz_clear: got %b want 0", DivZero); end
    checks++; if (Lo !== 32'd1) begin errors++; $display("FAIL dz_next_lo: got %h want 1", Lo); end
  endtask

  task automatic test_mt();
    int lat, dn;
    bit held;
    logic [31:0] lo0;
    lo0 = Lo;
    MtHi = 1'b1; WData = 32'h1234;
    @(negedge clk);
    MtHi = 1'b0;
    checks++; if (Hi !== 32'h1234) begin errors++; $display("FAIL mthi: got %h want 00001234", Hi); end
    checks++; if (Lo !== lo0) begin errors++; $display("FAIL mthi_lo_kept: got %h want %h", Lo, lo0); end
    run_op(MD_MULTU, 32'd2, 32'd3, 1'b1, 32'hDEAD_BEEF, lat, dn, held);
    checks++; if (Lo !== 32'd6) begin errors++; $display("FAIL mtlo_with_start_lo: got %h want 6", Lo); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL mtlo_with_start_hi: got %h want 0", Hi); end
    MtHi = 1'b1; MtLo = 1'b1; WData = 32'hA5A5_5A5A;
    @(negedge clk);
    MtHi = 1'b0; MtLo = 1'b0;
    checks++; if (Hi !== 32'hA5A5_5A5A) begin errors++; $display("FAIL mt_both_hi: got %h want a5a55a5a", Hi); end
    checks++; if (Lo !== 32'hA5A5_5A5A) begin errors++; $display("FAIL mt_both_lo: got %h want a5a55a5a", Lo); end
  endtask

  task automatic test_start_while_busy();
    int lat;
    lat = -1;
    MdOp = MD_MULTU; A = 32'd7; B = 32'd6; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    for (int c = 1; c <= 60 && lat < 0; c++) begin
      if (c == 5)  begin MtHi = 1'b1; WData = 32'h0BAD_0BAD; end
      if (c == 6)  MtHi = 1'b0;
      if (c == 10) begin MdOp = MD_DIVU; A = 32'd9; B = 32'd0; Start = 1'b1; end
      if (c == 11) Start = 1'b0;
      @(negedge clk);
      if (Done === 1'b1) lat = c;
    end
    checks++; if (lat != 33) begin errors++; $display("FAIL busy_start_latency: got %0d want 33", lat); end
    checks++; if (Lo !== 32'd42) begin errors++; $display("FAIL busy_start_lo: got %h want 2a", Lo); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL busy_mthi_ignored: got %h want 0", Hi); end
    checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL busy_start_dz: got %b want 0", DivZero); end
    @(negedge clk);
  endtask

  task automatic test_abort();
    int dn;
    dn = 0;
    MdOp = MD_MULTU; A = 32'h0001_2345; B = 32'h0000_0777; Start = 1'b1;
    @(negedge clk);
    Start = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 10) begin MdOp = MD_DIVU; A = 32'd5; B = 32'd0; Start = 1'b1; end
      if (c == 11) Start = 1'b0;
      if (c == 20) reset = 1'b1;
      @(negedge clk);
      if (Done === 1'b1) dn++;
      if (c == 15) begin
        checks++; if (DivZero !== 1'b0) begin errors++; $display("FAIL abort_ignored_start_dz: got %b want 0", DivZero); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL abort_still_busy: got %b want 1", Busy); end
      end
    end
    reset = 1'b0;
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %b want 0", Busy); end
    checks++; if (Hi !== 32'd0) begin errors++; $display("FAIL abort_hi: got %h want 0", Hi); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL abort_lo: got %h want 0", Lo); end
    repeat (40) begin
      @(negedge clk);
      if (Done === 1'b1) dn++;
    end
    checks++; if (dn != 0) begin errors++; $display("FAIL abort_no_done: got %0d want 0", dn); end
    checks++; if (Lo !== 32'd0) begin errors++; $display("FAIL abort_lo_after: got %h want 0", Lo); end
  endtask

  task automatic test_random();
    logic [1:0]  op;
    logic [31:0] a, b, eh, el;
    int lat, dn, elat;
    bit held;
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      a = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'd1;
        default: b = $urandom;
      endcase
      model(op, a, b, eh, el);
      elat = (op[1] && b == 32'd0) ? 1 : 33;
      run_op(op, a, b, 1'b0, 32'd0, lat, dn, held);
      checks++; if (Hi !== eh) begin errors++; $display("FAIL rnd%0d_hi op=%0d a=%h b=%h: got %h want %h", i, op, a, b, Hi, eh); end
      checks++; if (Lo !== el) begin errors++; $display("FAIL rnd%0d_lo op=%0d a=%h b=%h: got %h want %h", i, op, a, b, Lo, el); end
      checks++; if (lat != elat) begin errors++; $display("FAIL rnd%0d_latency: got %0d want %0d", i, lat, elat); end
      checks++; if (dn != 1) begin errors++; $display("FAIL rnd%0d_done_count: got %0d want 1", i, dn); end
      checks++; if (DivZero !== (op[1] && b == 32'd0)) begin errors++; $display("FAIL rnd%0d_dz: got %b want %b", i, DivZero, (op[1] && b == 32'd0)); end
    end
  endtask

  initial begin
    reset = 1'b1; Start = 1'b0; MdOp = 2'b00; A = '0; B = '0;
    MtHi = 1'b0; MtLo = 1'b0; WData = '0;
    test_reset();
    test_directed();
    test_divzero();
    test_mt();
    test_abort();
    test_start_while_busy();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
